// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe. The master side issues operand
// pairs and consumes results; the slave side is the multiplier itself.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_p;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag, out_flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage IEEE-754 binary multiplier.
//   S1 unpacks, classifies and forms the full mantissa product and biased exponent sum.
//   S2 normalises the product and extracts fraction, guard, round and sticky bits.
//   S3 rounds to nearest-even, detects overflow/underflow and packs the result.
// Subnormal inputs are treated as zero and tiny results flush to zero.
// All stages advance together whenever the output register is free or being drained.
module fp_mul_pipe #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  fp_mul_pipe_if.slave bus
);

  localparam int W    = 1 + EXP_W + MAN_W;  // packed operand width
  localparam int PW   = 2 * MAN_W + 2;      // full mantissa product width
  localparam int EW   = EXP_W + 2;          // signed working exponent width
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;

  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] EXP_OVF  = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Flag vector layout: {invalid, div0, overflow, underflow, inexact}
  localparam logic [4:0] FLAGS_NONE = 5'b00000;
  localparam logic [4:0] FLAGS_INV  = 5'b10000;
  localparam logic [4:0] FLAGS_OVF  = 5'b00101;
  localparam logic [4:0] FLAGS_UNF  = 5'b00011;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic w_adv;
  logic r_s1_valid;
  logic r_s2_valid;
  logic r_s3_valid;

  assign w_adv        = !r_s3_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Valid bits shift as one chain; reset empties the pipe so in-flight ops are dropped
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all stages sample pre-edge values.
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= bus.in_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: unpack, classify, multiply
  // ---------------------------------------------------------------------------
  logic                 w_s1_sa;
  logic                 w_s1_sb;
  logic                 w_s1_sign;
  logic [EXP_W-1:0]     w_s1_ea;
  logic [EXP_W-1:0]     w_s1_eb;
  logic [MAN_W-1:0]     w_s1_fa;
  logic [MAN_W-1:0]     w_s1_fb;
  logic                 w_a_zero;
  logic                 w_a_inf;
  logic                 w_a_nan;
  logic                 w_b_zero;
  logic                 w_b_inf;
  logic                 w_b_nan;
  logic [PW-1:0]        w_s1_prod;
  logic signed [EW-1:0] w_s1_esum;
  logic                 w_s1_special;
  logic                 w_s1_invalid;
  logic [W-1:0]         w_s1_spec_p;

  assign {w_s1_sa, w_s1_ea, w_s1_fa} = bus.in_a;
  assign {w_s1_sb, w_s1_eb, w_s1_fb} = bus.in_b;
  assign w_s1_sign = w_s1_sa ^ w_s1_sb;

  // A zero exponent field covers both true zero and subnormals (treated as zero)
  assign w_a_zero = (w_s1_ea == '0);
  assign w_a_inf  = (w_s1_ea == EXP_ONES) && (w_s1_fa == '0);
  assign w_a_nan  = (w_s1_ea == EXP_ONES) && (w_s1_fa != '0);
  assign w_b_zero = (w_s1_eb == '0);
  assign w_b_inf  = (w_s1_eb == EXP_ONES) && (w_s1_fb == '0);
  assign w_b_nan  = (w_s1_eb == EXP_ONES) && (w_s1_fb != '0);

  assign w_s1_prod = {{(MAN_W+1){1'b0}}, 1'b1, w_s1_fa}
                   * {{(MAN_W+1){1'b0}}, 1'b1, w_s1_fb};
  assign w_s1_esum = EW'(w_s1_ea) + EW'(w_s1_eb) - EW'(BIAS);

  // Special operands bypass the arithmetic path; earlier branches win
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_s1_special = 1'b0;
    w_s1_invalid = 1'b0;
    w_s1_spec_p  = '0;
    if (w_a_nan || w_b_nan) begin
      w_s1_special = 1'b1;
      w_s1_spec_p  = QNAN;
    end else if ((w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
      w_s1_special = 1'b1;
      w_s1_invalid = 1'b1;
      w_s1_spec_p  = QNAN;
    end else if (w_a_inf || w_b_inf) begin
      w_s1_special = 1'b1;
      w_s1_spec_p  = {w_s1_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_a_zero || w_b_zero) begin
      w_s1_special = 1'b1;
      w_s1_spec_p  = {w_s1_sign, {(W-1){1'b0}}};
    end
  end

  logic [TAG_W-1:0]     r_s1_tag;
  logic                 r_s1_sign;
  logic [PW-1:0]        r_s1_prod;
  logic signed [EW-1:0] r_s1_esum;
  logic                 r_s1_special;
  logic                 r_s1_invalid;
  logic [W-1:0]         r_s1_spec_p;

  // Stage 1 payload, loaded only for real ops so bubbles leave the data untouched
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; the valid chain alone decides what is live.
    if (w_adv && bus.in_valid) begin
      r_s1_tag     <= bus.in_tag;
      r_s1_sign    <= w_s1_sign;
      r_s1_prod    <= w_s1_prod;
      r_s1_esum    <= w_s1_esum;
      r_s1_special <= w_s1_special;
      r_s1_invalid <= w_s1_invalid;
      r_s1_spec_p  <= w_s1_spec_p;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: normalise and extract guard/round/sticky
  // ---------------------------------------------------------------------------
  logic [MAN_W-1:0]     w_s2_frac;
  logic                 w_s2_g;
  logic                 w_s2_r;
  logic                 w_s2_s;
  logic signed [EW-1:0] w_s2_exp;

  // The product of two [1,2) mantissas lies in [1,4); a set MSB means one right shift
  always_comb begin
    w_s2_frac = '0;
    w_s2_g    = 1'b0;
    w_s2_r    = 1'b0;
    w_s2_s    = 1'b0;
    w_s2_exp  = r_s1_esum;
    if (r_s1_prod[PW-1]) begin
      w_s2_frac = r_s1_prod[PW-2 -: MAN_W];
      w_s2_g    = r_s1_prod[MAN_W];
      w_s2_r    = r_s1_prod[MAN_W-1];
      w_s2_s    = |r_s1_prod[MAN_W-2:0];
      w_s2_exp  = r_s1_esum + EW'(1);
    end else begin
      w_s2_frac = r_s1_prod[PW-3 -: MAN_W];
      w_s2_g    = r_s1_prod[MAN_W-1];
      w_s2_r    = r_s1_prod[MAN_W-2];
      w_s2_s    = |r_s1_prod[MAN_W-3:0];
    end
  end

  logic [TAG_W-1:0]     r_s2_tag;
  logic                 r_s2_sign;
  logic [MAN_W-1:0]     r_s2_frac;
  logic                 r_s2_g;
  logic                 r_s2_r;
  logic                 r_s2_s;
  logic signed [EW-1:0] r_s2_exp;
  logic                 r_s2_special;
  logic                 r_s2_invalid;
  logic [W-1:0]         r_s2_spec_p;

  // Stage 2 payload
  always_ff @(posedge clk) begin
    if (w_adv && r_s1_valid) begin
      r_s2_tag     <= r_s1_tag;
      r_s2_sign    <= r_s1_sign;
      r_s2_frac    <= w_s2_frac;
      r_s2_g       <= w_s2_g;
      r_s2_r       <= w_s2_r;
      r_s2_s       <= w_s2_s;
      r_s2_exp     <= w_s2_exp;
      r_s2_special <= r_s1_special;
      r_s2_invalid <= r_s1_invalid;
      r_s2_spec_p  <= r_s1_spec_p;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: round to nearest-even, range check, pack
  // ---------------------------------------------------------------------------
  logic                 w_s3_inc;
  logic [MAN_W:0]       w_s3_sum;
  logic                 w_s3_carry;
  logic signed [EW-1:0] w_s3_exp;
  logic                 w_s3_inexact;
  logic [W-1:0]         w_s3_p;
  logic [4:0]           w_s3_flags;

  assign w_s3_inc     = r_s2_g && (r_s2_r || r_s2_s || r_s2_frac[0]);
  assign w_s3_sum     = {1'b0, r_s2_frac} + (MAN_W+1)'(w_s3_inc);
  // A carry out of an all-ones fraction leaves the fraction at zero and bumps the exponent
  assign w_s3_carry   = w_s3_sum[MAN_W];
  assign w_s3_exp     = r_s2_exp + $signed({{(EW-1){1'b0}}, w_s3_carry});
  assign w_s3_inexact = r_s2_g || r_s2_r || r_s2_s;

  // Final result selection: specials, then overflow to inf, underflow to zero, else normal
  always_comb begin
    w_s3_p     = {r_s2_sign, w_s3_exp[EXP_W-1:0], w_s3_sum[MAN_W-1:0]};
    w_s3_flags = {4'b0000, w_s3_inexact};
    if (r_s2_special) begin
      w_s3_p     = r_s2_spec_p;
      w_s3_flags = r_s2_invalid ? FLAGS_INV : FLAGS_NONE;
    end else if (w_s3_exp >= EXP_OVF) begin
      w_s3_p     = {r_s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      w_s3_flags = FLAGS_OVF;
    end else if (w_s3_exp <= EXP_ZERO) begin
      w_s3_p     = {r_s2_sign, {(W-1){1'b0}}};
      w_s3_flags = FLAGS_UNF;
    end
  end

  logic [W-1:0]     r_s3_p;
  logic [TAG_W-1:0] r_s3_tag;
  logic [4:0]       r_s3_flags;

  // Output register: zero after reset, frozen while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s3_p     <= '0;
      r_s3_tag   <= '0;
      r_s3_flags <= '0;
    end else if (w_adv && r_s2_valid) begin
      r_s3_p     <= w_s3_p;
      r_s3_tag   <= r_s2_tag;
      r_s3_flags <= w_s3_flags;
    end
  end

  assign bus.out_valid = r_s3_valid;
  assign bus.out_p     = r_s3_p;
  assign bus.out_tag   = r_s3_tag;
  assign bus.out_flags = r_s3_flags;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe in binary64. Expected results come from an exact-integer
// reference: the full mantissa product is rounded by comparing the discarded
// remainder against one half ulp.
module tb_fp_mul_pipe;

  localparam int EXP_W = 11;
  localparam int MAN_W = 52;
  localparam int TAG_W = 4;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  typedef struct packed {
    logic [63:0] p;
    logic [4:0]  flags;
  } res_t;

  typedef struct packed {
    logic [63:0] p;
    logic [4:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
    logic [4:0]  f;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  fp_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference product: classify, then round the exact integer product
  function automatic res_t ref_mul(input logic [63:0] a, input logic [63:0] b);
    res_t r;
    logic sign;
    int ea, eb, e, drop;
    logic [51:0] fa, fb;
    logic za, zb, ia, ib, na, nb;
    logic [105:0] m, q, rem, half;
    ea = int'(a[62:52]); eb = int'(b[62:52]);
    fa = a[51:0];        fb = b[51:0];
    sign = a[63] ^ b[63];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 2047) && (fa == 0); ib = (eb == 2047) && (fb == 0);
    na = (ea == 2047) && (fa != 0); nb = (eb == 2047) && (fb != 0);
    if (na || nb) begin r.p = QNAN; r.flags = 5'b00000; return r; end
    if ((za && ib) || (ia && zb)) begin r.p = QNAN; r.flags = 5'b10000; return r; end
    if (ia || ib) begin r.p = {sign, 11'h7FF, 52'd0}; r.flags = 5'b00000; return r; end
    if (za || zb) begin r.p = {sign, 63'd0}; r.flags = 5'b00000; return r; end
    m    = {53'd0, 1'b1, fa} * {53'd0, 1'b1, fb};
    drop = m[105] ? 53 : 52;
    q    = m >> drop;
    rem  = m - (q << drop);
    half = 106'd1 << (drop - 1);
    e    = ea + eb - 1023 + (drop - 52);
    if (rem > half || (rem == half && q[0])) q = q + 106'd1;
    if (q == (106'd1 << 53)) begin q = q >> 1; e = e + 1; end
    if (e >= 2047) begin r.p = {sign, 11'h7FF, 52'd0}; r.flags = 5'b00101; return r; end
    if (e <= 0) begin r.p = {sign, 63'd0}; r.flags = 5'b00011; return r; end
    r.p = {sign, e[10:0], q[51:0]};
    r.flags = {4'b0000, rem != 0};
    return r;
  endfunction

  // Random operand biased towards specials and exponent ranges that overflow/underflow
  function automatic logic [63:0] gen_operand();
    logic [63:0] t;
    logic [10:0] e;
    logic [51:0] f;
    int k;
    t = {$urandom(), $urandom()};
    f = t[51:0];
    k = int'($urandom_range(0, 15));
    case (k)
      0:       begin e = 11'd0; if (t[63]) f = '0; end
      1:       begin e = 11'h7FF; if (t[62]) f = '0; end
      2, 3:    e = 11'($urandom_range(1500, 2046));
      4, 5:    e = 11'($urandom_range(1, 520));
      6:       begin e = 11'($urandom_range(1000, 1050)); f = {t[51:46], 46'd0}; end
      default: e = 11'($urandom_range(900, 1150));
    endcase
    return {t[60], e, f};
  endfunction

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_tag   = '0;
  endtask

  // Issue one op on an idle pipe and wait (bounded) for its result
  task automatic run_one(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                         output res_t r, output logic [3:0] t, output bit timeout);
    int n;
    r = '0; t = '0; timeout = 1'b1; n = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    #1;
    while (!bus.in_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) begin
        r.p = bus.out_p; r.flags = bus.out_flags; t = bus.out_tag; timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_p !== 64'd0) begin errors++; $display("FAIL reset_out_p: got %h expected 0", bus.out_p); end
    checks++; if (bus.out_tag !== 4'd0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", bus.out_tag); end
    checks++; if (bus.out_flags !== 5'd0) begin errors++; $display("FAIL reset_out_flags: got %b expected 0", bus.out_flags); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_directed();
    vec_t v [17];
    res_t r;
    logic [3:0] t;
    bit to;
    v[0]  = '{64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000, 5'b00000};
    v[1]  = '{64'hBFF8000000000000, 64'h4014000000000000, 64'hC01E000000000000, 5'b00000};
    v[2]  = '{64'hC014000000000000, 64'hC014000000000000, 64'h4039000000000000, 5'b00000};
    v[3]  = '{64'h4024000000000000, 64'h3FB999999999999A, 64'h3FF0000000000000, 5'b00001};
    v[4]  = '{64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002, 5'b00001};
    v[5]  = '{64'h0000000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 5'b10000};
    v[6]  = '{64'h7FE0000000000000, 64'h4000000000000000, 64'h7FF0000000000000, 5'b00101};
    v[7]  = '{64'h0010000000000000, 64'h3FE0000000000000, 64'h0000000000000000, 5'b00011};
    v[8]  = '{64'hC000000000000000, 64'h0000000000000000, 64'h8000000000000000, 5'b00000};
    v[9]  = '{64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'b00000};
    v[10] = '{64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 5'b00000};
    v[11] = '{64'h000FFFFFFFFFFFFF, 64'hC000000000000000, 64'h8000000000000000, 5'b00000};
    v[12] = '{64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 64'h7FF8000000000000, 5'b00000};
    v[13] = '{64'h7FE0000000000000, 64'h3FF0000000000000, 64'h7FE0000000000000, 5'b00000};
    v[14] = '{64'h0010000000000000, 64'h3FF0000000000000, 64'h0010000000000000, 5'b00000};
    v[15] = '{64'h7FEFFFFFFFFFFFFF, 64'h3FF0000000000001, 64'h7FF0000000000000, 5'b00101};
    v[16] = '{64'h3FF0000000000001, 64'h3FFFFFFFFFFFFFFE, 64'h4000000000000000, 5'b00001};
    for (int i = 0; i < 17; i++) begin
      run_one(v[i].a, v[i].b, 4'(i), r, t, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL directed_%0d timeout: no out_valid within bound", i);
      end else begin
        if (r.p !== v[i].p) begin errors++; $display("FAIL directed_%0d product: got %h expected %h", i, r.p, v[i].p); end
        checks++; if (r.flags !== v[i].f) begin errors++; $display("FAIL directed_%0d flags: got %b expected %b", i, r.flags, v[i].f); end
        checks++; if (t !== 4'(i)) begin errors++; $display("FAIL directed_%0d tag: got %h expected %h", i, t, 4'(i)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t m [8];
    logic [63:0] a, b;
    bit exp_valid;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (c < 8) begin
        a = gen_operand(); b = gen_operand();
        m[c] = ref_mul(a, b);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_tag = 4'(c);
      end else begin
        drive_idle();
      end
      #1;
      if (c < 8) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle %0d: got %b expected 1", c, bus.in_ready); end
      end
      exp_valid = (c >= 3) && (c <= 10);
      checks++;
      if (bus.out_valid !== exp_valid) begin
        errors++; $display("FAIL b2b_out_valid cycle %0d: got %b expected %b", c, bus.out_valid, exp_valid);
      end else if (exp_valid) begin
        checks++; if (bus.out_tag !== 4'(c-3)) begin errors++; $display("FAIL b2b_tag cycle %0d: got %h expected %h", c, bus.out_tag, 4'(c-3)); end
        checks++; if (bus.out_p !== m[c-3].p || bus.out_flags !== m[c-3].flags) begin
          errors++; $display("FAIL b2b_result cycle %0d: got %h/%b expected %h/%b", c, bus.out_p, bus.out_flags, m[c-3].p, m[c-3].flags);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    res_t m [4];
    logic [63:0] a [4];
    logic [63:0] b [4];
    int issued, retired, c;
    issued = 0; retired = 0;
    for (int i = 0; i < 4; i++) begin
      a[i] = gen_operand(); b[i] = gen_operand(); m[i] = ref_mul(a[i], b[i]);
    end
    // Stall window: consumer refuses for 9 cycles, the last 6 with a full pipe
    for (c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = (issued < 4);
      bus.in_a      = a[issued % 4]; bus.in_b = b[issued % 4]; bus.in_tag = 4'(8 + issued);
      #1;
      if (c >= 3) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_p !== m[0].p || bus.out_tag !== 4'd8) begin
          errors++; $display("FAIL bp_hold cycle %0d: got v=%b p=%h tag=%h expected v=1 p=%h tag=8", c, bus.out_valid, bus.out_p, bus.out_tag, m[0].p);
        end
      end
      if (bus.in_valid && bus.in_ready) issued++;
    end
    checks++; if (issued != 3) begin errors++; $display("FAIL bp_accepted_while_stalled: got %0d expected 3", issued); end
    // Release and drain in order
    for (c = 0; c < 20 && retired < 4; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (issued < 4);
      bus.in_a      = a[issued % 4]; bus.in_b = b[issued % 4]; bus.in_tag = 4'(8 + issued);
      #1;
      if (bus.out_valid) begin
        checks++;
        if (bus.out_tag !== 4'(8 + retired) || bus.out_p !== m[retired].p || bus.out_flags !== m[retired].flags) begin
          errors++; $display("FAIL bp_drain_%0d: got tag=%h p=%h f=%b expected tag=%h p=%h f=%b", retired,
                             bus.out_tag, bus.out_p, bus.out_flags, 4'(8 + retired), m[retired].p, m[retired].flags);
        end
        retired++;
      end
      if (bus.in_valid && bus.in_ready) issued++;
    end
    drive_idle();
    checks++; if (retired != 4) begin errors++; $display("FAIL bp_retired_count: got %0d expected 4", retired); end
    for (c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate cycle %0d: got out_valid %b expected 0", c, bus.out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a = gen_operand(); bus.in_b = gen_operand(); bus.in_tag = 4'(c + 1);
    end
    @(negedge clk);
    drive_idle();
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd1) begin
      errors++; $display("FAIL rst_mid_inflight: got v=%b tag=%h expected v=1 tag=1", bus.out_valid, bus.out_tag);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_p !== 64'd0 || bus.out_tag !== 4'd0 || bus.out_flags !== 5'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got p=%h tag=%h f=%b expected all 0", bus.out_p, bus.out_tag, bus.out_flags);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale cycle %0d: got out_valid %b expected 0", c, bus.out_valid); end
    end
  endtask

  task automatic test_random();
    localparam int N = 400;
    exp_t sb [$];
    exp_t e;
    res_t r;
    logic [63:0] a, b, prev_p;
    bit have, prev_stall;
    int sent, got;
    sent = 0; got = 0; have = 1'b0; prev_stall = 1'b0; prev_p = '0; a = '0; b = '0;
    for (int c = 0; c < 6000 && got < N; c++) begin
      @(negedge clk);
      if (!have && sent < N) begin a = gen_operand(); b = gen_operand(); have = 1'b1; end
      bus.in_valid  = have && ($urandom_range(0, 3) != 0);
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_tag    = sent[3:0];
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        errors++; $display("FAIL rand_in_ready cycle %0d: got %b expected %b", c, bus.in_ready, !bus.out_valid || bus.out_ready);
      end
      if (prev_stall) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_p !== prev_p) begin
          errors++; $display("FAIL rand_hold cycle %0d: got v=%b p=%h expected v=1 p=%h", c, bus.out_valid, bus.out_p, prev_p);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_p     = bus.out_p;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_unexpected cycle %0d: got result tag=%h expected none", c, bus.out_tag);
        end else begin
          e = sb.pop_front();
          if (bus.out_p !== e.p || bus.out_flags !== e.flags || bus.out_tag !== e.tag) begin
            errors++; $display("FAIL rand_result_%0d: got p=%h f=%b tag=%h expected p=%h f=%b tag=%h", got,
                               bus.out_p, bus.out_flags, bus.out_tag, e.p, e.flags, e.tag);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        r = ref_mul(a, b);
        e.p = r.p; e.flags = r.flags; e.tag = sent[3:0];
        sb.push_back(e);
        sent++;
        have = 1'b0;
      end
    end
    drive_idle();
    checks++; if (got != N) begin errors++; $display("FAIL rand_count: got %0d results expected %0d", got, N); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
